// File: rtl/clk_meas_pkg.sv
// Shared definitions for the slow-clock period meter.
// Contents: FSM state encoding, system clock rate, default counter width and timeout.
package clk_meas_pkg;

  localparam int unsigned SYS_CLK_HZ      = 10_000_000;
  localparam int unsigned CNT_W_DEFAULT   = 24;
  // 1.5 s at SYS_CLK_HZ: long enough for a 1 Hz tick plus margin.
  localparam int unsigned TIMEOUT_DEFAULT = 15_000_000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2,
    HOLD      = 2'd3
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer for an asynchronous input plus a rising-edge pulse.
// Ports:
//   clk     in   system clock
//   reset   in   synchronous active-high reset, clears the whole chain
//   sig_in  in   asynchronous input
//   sync_q  out  synchronized level (last flop of the chain)
//   rise    out  one-cycle pulse when sync_q goes 0 -> 1
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic sync_q,
  output logic rise
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_edge_det: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   sync_dly_q;

  // Shift chain; bit 0 is the metastability-exposed flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q    <= '0;
      sync_dly_q <= 1'b0;
    end else begin
      chain_q    <= {chain_q[SYNC_STAGES-2:0], sig_in};
      sync_dly_q <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync_q = chain_q[SYNC_STAGES-1];
  assign rise   = sync_q & ~sync_dly_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of a slow asynchronous square wave in system clock
// cycles and returns it over a valid/ready handshake. A phase that exceeds
// TIMEOUT cycles yields a timeout result with period 0.
// Optional feature macro: CLK_MEAS_DUTY_EN adds the high_time output.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset, aborts any measurement
//   sig_in      in   asynchronous signal under measurement
//   start       in   request one measurement (only honoured in IDLE)
//   busy        out  state is not IDLE
//   meas_valid  out  result available, held until accepted
//   meas_ready  in   consumer accepts when meas_valid & meas_ready
//   period      out  measured period in clk cycles, 0 on timeout
//   timeout     out  result is a timeout
//   high_time   out  (CLK_MEAS_DUTY_EN only) high cycles within the period
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] period,
`ifdef CLK_MEAS_DUTY_EN
  output logic [CNT_W-1:0] high_time,
`endif
  output logic             timeout
);

  // The counter must reach TIMEOUT without wrapping.
  if (64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
    $error("clk_period_meter: TIMEOUT must be below 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic sync_lvl;
  logic rise;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .sync_q (sync_lvl),
    .rise   (rise)
  );

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] period_q,  period_d;
  logic             timeout_q, timeout_d;
`ifdef CLK_MEAS_DUTY_EN
  logic [CNT_W-1:0] hcnt_q,    hcnt_d;
  logic [CNT_W-1:0] high_q,    high_d;
`else
  logic sync_unused;
  assign sync_unused = sync_lvl;
`endif

  // State and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      timeout_q <= 1'b0;
`ifdef CLK_MEAS_DUTY_EN
      hcnt_q    <= '0;
      high_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      timeout_q <= timeout_d;
`ifdef CLK_MEAS_DUTY_EN
      hcnt_q    <= hcnt_d;
      high_q    <= high_d;
`endif
    end
  end

  // Next-state, counter and result update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    timeout_d = timeout_q;
`ifdef CLK_MEAS_DUTY_EN
    hcnt_d    = hcnt_q;
    high_d    = high_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_EDGE;
          cnt_d   = ONE_C;
`ifdef CLK_MEAS_DUTY_EN
          hcnt_d  = '0;
`endif
        end
      end
      WAIT_EDGE: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = ONE_C;
`ifdef CLK_MEAS_DUTY_EN
          // The first-edge cycle is already a high cycle of the period.
          hcnt_d  = CNT_W'(sync_lvl);
`endif
        end else if (cnt_q == TIMEOUT_C) begin
          state_d   = HOLD;
          timeout_d = 1'b1;
          period_d  = '0;
`ifdef CLK_MEAS_DUTY_EN
          high_d    = '0;
`endif
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      MEASURE: begin
        // A rise coinciding with the limit still counts as a measurement.
        if (rise) begin
          state_d   = HOLD;
          period_d  = cnt_q;
          timeout_d = 1'b0;
`ifdef CLK_MEAS_DUTY_EN
          high_d    = hcnt_q;
`endif
        end else if (cnt_q == TIMEOUT_C) begin
          state_d   = HOLD;
          timeout_d = 1'b1;
          period_d  = '0;
`ifdef CLK_MEAS_DUTY_EN
          high_d    = '0;
`endif
        end else begin
          cnt_d = cnt_q + ONE_C;
`ifdef CLK_MEAS_DUTY_EN
          if (sync_lvl) begin
            hcnt_d = hcnt_q + ONE_C;
          end
`endif
        end
      end
      HOLD: begin
        if (meas_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign meas_valid = (state_q == HOLD);
  assign period     = period_q;
  assign timeout    = timeout_q;
`ifdef CLK_MEAS_DUTY_EN
  assign high_time  = high_q;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter built with TIMEOUT=100.
// Follows CLK_MEAS_DUTY_EN to check high_time when the port exists.
module tb_clk_period_meter;

  localparam int unsigned CNT_W = 24;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sig_in = 1'b0;
  logic             start = 1'b0;
  logic             busy;
  logic             meas_valid;
  logic             meas_ready = 1'b1;
  logic [CNT_W-1:0] period;
  logic             timeout;
`ifdef CLK_MEAS_DUTY_EN
  logic [CNT_W-1:0] high_time;
`endif

  int total = 0;
  int bad   = 0;

  // Square-wave generator controls.
  logic sig_en = 1'b0;
  int   hi_len = 10;
  int   lo_len = 10;
  int   ph     = 0;

  clk_period_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2),
    .TIMEOUT     (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .start      (start),
    .busy       (busy),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .period     (period),
`ifdef CLK_MEAS_DUTY_EN
    .high_time  (high_time),
`endif
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // sig_in changes 2 time units after posedge: high for hi_len, low for lo_len.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!sig_en) begin
        sig_in = 1'b0;
        ph     = 0;
      end else begin
        sig_in = (ph < hi_len);
        ph     = (ph + 1 == hi_len + lo_len) ? 0 : ph + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (meas_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid_seen"}, 32'(meas_valid), 32'd1);
  endtask

  // Quiet input, pulse start, then enable the square wave.
  task automatic measure_setup(input int hi, input int lo);
    sig_en = 1'b0;
    hi_len = hi;
    lo_len = lo;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    sig_en = 1'b1;
  endtask

  initial begin
    int stable_bad;
    int busy_cnt;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(meas_valid), 32'd0);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
`ifdef CLK_MEAS_DUTY_EN
    chk("rst_high", 32'(high_time), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // 1: period 20, 10 high / 10 low
    measure_setup(10, 10);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_valid("t1", 300);
    chk("t1_period", 32'(period), 32'd20);
    chk("t1_timeout", 32'(timeout), 32'd0);
`ifdef CLK_MEAS_DUTY_EN
    chk("t1_high", 32'(high_time), 32'd10);
`endif
    @(negedge clk);
    chk("t1_valid_drop", 32'(meas_valid), 32'd0);
    chk("t1_busy_drop", 32'(busy), 32'd0);

    // 2: input held low, timeout after exactly 100 cycles in WAIT_EDGE
    sig_en = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t2_busy", 32'(busy), 32'd1);
    repeat (99) @(negedge clk);
    chk("t2_not_yet", 32'(meas_valid), 32'd0);
    @(negedge clk);
    chk("t2_valid", 32'(meas_valid), 32'd1);
    chk("t2_timeout", 32'(timeout), 32'd1);
    chk("t2_period", 32'(period), 32'd0);
    @(negedge clk);
    chk("t2_valid_drop", 32'(meas_valid), 32'd0);

    // 3: consumer stalls 50 cycles, start during HOLD is ignored
    meas_ready = 1'b0;
    measure_setup(10, 10);
    wait_valid("t3", 300);
    chk("t3_period", 32'(period), 32'd20);
    stable_bad = 0;
    for (int i = 0; i < 50; i++) begin
      start = (i == 10);
      @(negedge clk);
      if (meas_valid !== 1'b1 || period !== 24'd20 || timeout !== 1'b0) stable_bad++;
    end
    start = 1'b0;
    chk("t3_hold_stable", 32'(stable_bad), 32'd0);
    meas_ready = 1'b1;
    @(negedge clk);
    chk("t3_valid_drop", 32'(meas_valid), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_cnt++;
    end
    chk("t3_no_queue", 32'(busy_cnt), 32'd0);

    // 4: reset 5 cycles into MEASURE, with start asserted alongside
    measure_setup(10, 10);
    repeat (9) @(negedge clk);
    chk("t4_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_valid", 32'(meas_valid), 32'd0);
    chk("t4_period", 32'(period), 32'd0);
    chk("t4_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("t4_stay_idle", 32'(busy), 32'd0);
    measure_setup(10, 10);
    wait_valid("t4", 300);
    chk("t4_period_again", 32'(period), 32'd20);
    @(negedge clk);

    // 5: period at the limit is measured, one beyond times out
    measure_setup(50, 50);
    wait_valid("t5a", 400);
    chk("t5a_period", 32'(period), 32'd100);
    chk("t5a_timeout", 32'(timeout), 32'd0);
`ifdef CLK_MEAS_DUTY_EN
    chk("t5a_high", 32'(high_time), 32'd50);
`endif
    @(negedge clk);
    measure_setup(50, 51);
    wait_valid("t5b", 400);
    chk("t5b_period", 32'(period), 32'd0);
    chk("t5b_timeout", 32'(timeout), 32'd1);
`ifdef CLK_MEAS_DUTY_EN
    chk("t5b_high", 32'(high_time), 32'd0);
`endif
    @(negedge clk);

    // 6: 5 high / 15 low
    measure_setup(5, 15);
    wait_valid("t6", 300);
    chk("t6_period", 32'(period), 32'd20);
    chk("t6_timeout", 32'(timeout), 32'd0);
`ifdef CLK_MEAS_DUTY_EN
    chk("t6_high", 32'(high_time), 32'd5);
`endif
    @(negedge clk);
    sig_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard against a stuck run.
  initial begin
    #500000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
